raifes_mul_div: RTL



---
 rtl/raifes_mul_div.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/raifes_mul_div.sv
// raifes_mul_div: iterative RV32M multiply/divide unit.
//   Multiply is radix-2 shift-add, divide is restoring shift-subtract, one bit
//   per cycle over 32 COMPUTE cycles. Signed operands are reduced to
//   magnitudes at accept and the result sign is fixed on the last iteration.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_op, req_in1, req_in2   funct3 operation and rs1/rs2 operands
//   kill                       abort in-flight operation, back to IDLE
//   resp_valid/resp_ready      response handshake
//   resp_result                registered result
// Build option: define RAIFES_MUL_DIV_FAST_SPECIAL_EN to short-cut divide by
//   zero, signed divide overflow and multiply by zero straight to DONE.
module raifes_mul_div #(
  localparam int unsigned XPR_LEN = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [XPR_LEN-1:0] req_in1,
  input  logic [XPR_LEN-1:0] req_in2,
  input  logic               kill,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [XPR_LEN-1:0] resp_result
);

  localparam int unsigned CNT_W = 5;
  localparam int unsigned ACC_W = 2 * XPR_LEN;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   counter;
  logic [2:0]         op;
  logic               neg_res;   // negate product or quotient
  logic               neg_rem;   // remainder takes dividend sign
  logic [XPR_LEN-1:0] opnd;      // multiplicand or divisor magnitude
  // Multiply: {high, low} product with multiplier shifting out of the low end.
  // Divide: {partial remainder, dividend/quotient shift register}.
  logic [ACC_W-1:0]   acc;

  // Operand sign decode at accept
  logic               sgn1_c, sgn2_c, neg1_c, neg2_c;
  logic [XPR_LEN-1:0] mag1_c, mag2_c;

  always_comb begin
    sgn1_c = (req_op == 3'b001) || (req_op == 3'b010) ||
             (req_op == 3'b100) || (req_op == 3'b110);
    sgn2_c = (req_op == 3'b001) || (req_op == 3'b100) || (req_op == 3'b110);
    neg1_c = sgn1_c && req_in1[XPR_LEN-1];
    neg2_c = sgn2_c && req_in2[XPR_LEN-1];
    mag1_c = neg1_c ? XPR_LEN'(-req_in1) : req_in1;
    mag2_c = neg2_c ? XPR_LEN'(-req_in2) : req_in2;
  end

  // One iteration of the datapath and the final sign-fixed result
  logic [XPR_LEN:0]   mul_sum_c, div_tmp_c, div_rem_c;
  logic               div_ge_c;
  logic [ACC_W-1:0]   step_c, prod_c;
  logic [XPR_LEN-1:0] quo_c, rem_c, result_c;

  always_comb begin
    mul_sum_c = {1'b0, acc[ACC_W-1:XPR_LEN]} +
                (acc[0] ? {1'b0, opnd} : (XPR_LEN+1)'(0));
    // Remainder stays below the divisor, so 32 stored bits plus the shifted-in
    // dividend bit form the 33-bit trial value.
    div_tmp_c = {acc[ACC_W-1:XPR_LEN], acc[XPR_LEN-1]};
    div_ge_c  = div_tmp_c >= {1'b0, opnd};
    div_rem_c = div_ge_c ? (XPR_LEN+1)'(div_tmp_c - {1'b0, opnd}) : div_tmp_c;
    step_c    = op[2] ? {div_rem_c[XPR_LEN-1:0], acc[XPR_LEN-2:0], div_ge_c}
                      : {mul_sum_c, acc[XPR_LEN-1:1]};
    prod_c    = neg_res ? ACC_W'(-step_c) : step_c;
    quo_c     = neg_res ? XPR_LEN'(-step_c[XPR_LEN-1:0]) : step_c[XPR_LEN-1:0];
    rem_c     = neg_rem ? XPR_LEN'(-step_c[ACC_W-1:XPR_LEN]) : step_c[ACC_W-1:XPR_LEN];
    if (op[2])
      result_c = op[1] ? rem_c : quo_c;
    else
      result_c = (op[1:0] == 2'b00) ? prod_c[XPR_LEN-1:0] : prod_c[ACC_W-1:XPR_LEN];
  end

`ifdef RAIFES_MUL_DIV_FAST_SPECIAL_EN
  // Special cases resolved at accept time
  logic               fast_hit_c;
  logic [XPR_LEN-1:0] fast_res_c;

  always_comb begin
    fast_hit_c = 1'b0;
    fast_res_c = '0;
    if (req_op[2]) begin
      if (req_in2 == '0) begin
        fast_hit_c = 1'b1;
        fast_res_c = req_op[1] ? req_in1 : '1;
      end else if (!req_op[0] && req_in1 == {1'b1, (XPR_LEN-1)'(0)} && req_in2 == '1) begin
        fast_hit_c = 1'b1;
        fast_res_c = req_op[1] ? '0 : req_in1;
      end
    end else if (req_in1 == '0 || req_in2 == '0) begin
      fast_hit_c = 1'b1;
      fast_res_c = '0;
    end
  end
`endif

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_result <= '0;
      counter     <= '0;
      op          <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      opnd        <= '0;
      acc         <= '0;
    end else if (kill) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op      <= req_op;
            neg_rem <= neg1_c;
            // Divide by zero keeps the all-ones quotient unsigned-looking
            neg_res <= (neg1_c ^ neg2_c) && !(req_op[2] && req_in2 == '0);
            opnd    <= req_op[2] ? mag2_c : mag1_c;
            acc     <= {XPR_LEN'(0), req_op[2] ? mag1_c : mag2_c};
            counter <= CNT_W'(31);
            req_ready <= 1'b0;
`ifdef RAIFES_MUL_DIV_FAST_SPECIAL_EN
            if (fast_hit_c) begin
              state       <= S_DONE;
              resp_valid  <= 1'b1;
              resp_result <= fast_res_c;
            end else begin
              state <= S_COMPUTE;
            end
`else
            state <= S_COMPUTE;
`endif
          end
        end
        S_COMPUTE: begin
          acc     <= step_c;
          counter <= CNT_W'(counter - CNT_W'(1));
          if (counter == '0) begin
            state       <= S_DONE;
            resp_valid  <= 1'b1;
            resp_result <= result_c;
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
